// File: rtl/mc_start_ctrl_pkg.sv
// Shared ALU definitions for the multi-cycle issue path: aluop width, mul/div codes, FSM state codes.
package mc_start_ctrl_pkg;

    localparam int         ALU_OPW    = 4;
    localparam logic [3:0] ALU_OP_MUL = 4'h2;
    localparam logic [3:0] ALU_OP_DIV = 4'h3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/mc_req_tracker.sv
// Remembers the last issued mul/div request and flags whether the current inputs are a new one.
// History is dropped on flush, timeout abort, or any cycle without a multi-cycle aluop.
module mc_req_tracker
    import mc_start_ctrl_pkg::*;
#(
    parameter int             WIDTH  = 32,
    parameter int             OPW    = ALU_OPW,
    parameter logic [OPW-1:0] OP_MUL = OPW'(ALU_OP_MUL),
    parameter logic [OPW-1:0] OP_DIV = OPW'(ALU_OP_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   aluop,
    input  logic             flush,
    input  logic             issue,
    input  logic             abort,
    output logic             req,
    output logic             match,
    output logic             newReq
);

    logic             histValid;
    logic [WIDTH-1:0] histA;
    logic [WIDTH-1:0] histB;
    logic [OPW-1:0]   histOp;

    assign req    = (aluop == OP_MUL) | (aluop == OP_DIV);
    assign match  = histValid & (a == histA) & (b == histB) & (aluop == histOp);
    assign newReq = req & ~match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            histValid <= 1'b0;
            histA     <= '0;
            histB     <= '0;
            histOp    <= '0;
        end else if (flush || abort) begin
            histValid <= 1'b0;
        end else if (issue) begin
            histValid <= 1'b1;
            histA     <= a;
            histB     <= b;
            histOp    <= aluop;
        end else if (!req) begin
            // An intervening non-mul/div instruction lets an identical op issue again.
            histValid <= 1'b0;
        end
    end

endmodule

// File: rtl/mc_start_ctrl.sv
// Issues mul/div requests to the iterative unit: latches operands, pulses start, stalls until done.
// Start one cycle after the request, done one cycle after unit_done; flush aborts, timeout sets a sticky error.
module mc_start_ctrl
    import mc_start_ctrl_pkg::*;
#(
    parameter int             WIDTH   = 32,
    parameter int             OPW     = ALU_OPW,
    parameter logic [OPW-1:0] OP_MUL  = OPW'(ALU_OP_MUL),
    parameter logic [OPW-1:0] OP_DIV  = OPW'(ALU_OP_DIV),
    parameter int             TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   aluop,
    input  logic             flush,
    input  logic             unit_done,
    output logic             start,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [OPW-1:0]   op_sel,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic          req;
    logic          match;
    logic          newReq;
    logic          issue;
    logic          abort;
    logic          cntLast;

    mc_req_tracker #(
        .WIDTH  (WIDTH),
        .OPW    (OPW),
        .OP_MUL (OP_MUL),
        .OP_DIV (OP_DIV)
    ) u_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .aluop  (aluop),
        .flush  (flush),
        .issue  (issue),
        .abort  (abort),
        .req    (req),
        .match  (match),
        .newReq (newReq)
    );

    assign busy    = (state == ST_BUSY);
    assign cntLast = (cnt == CW'(TIMEOUT - 1));
    assign issue   = (state == ST_IDLE) & newReq & ~flush;
    // A completion arriving on the last allowed cycle still counts as success.
    assign abort   = busy & ~flush & ~unit_done & cntLast;
    assign stall   = ~flush & req & (busy | newReq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            start       <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_sel      <= '0;
        end else begin
            start <= issue;
            done  <= busy & unit_done & ~flush;
            if (flush) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (issue) begin
                state  <= ST_BUSY;
                cnt    <= '0;
                op_a   <= a;
                op_b   <= b;
                op_sel <= aluop;
            end else if (busy) begin
                if (unit_done || cntLast) begin
                    state <= ST_IDLE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if (abort) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_start_ctrl.sv
// Directed and randomized checks of mc_start_ctrl against a cycle-level transaction model.
module tb_mc_start_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [3:0]  aluop;
    logic        flush, unit_done;
    logic        start, busy, stall, done, timeout_err;
    logic [31:0] op_a, op_b;
    logic [3:0]  op_sel;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state: in-flight flag, busy cycles elapsed (1-based), last issued op.
    bit          mBusy, mHistValid, mStart, mDone, mErr;
    int          mElapsed;
    logic [31:0] mHistA, mHistB, mOpA, mOpB;
    logic [3:0]  mHistOp, mOpSel;

    mc_start_ctrl #(.WIDTH(32), .OPW(4), .OP_MUL(4'h2), .OP_DIV(4'h3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .aluop(aluop), .flush(flush),
        .unit_done(unit_done), .start(start), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .busy(busy), .stall(stall), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic bit isReq(logic [3:0] op);
        return (op == 4'h2) || (op == 4'h3);
    endfunction

    function automatic bit modelNew();
        return isReq(aluop) &&
               !(mHistValid && a == mHistA && b == mHistB && aluop == mHistOp);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy = 0; mHistValid = 0; mStart = 0; mDone = 0; mErr = 0; mElapsed = 0;
        mHistA = '0; mHistB = '0; mHistOp = '0; mOpA = '0; mOpB = '0; mOpSel = '0;
    endtask

    task automatic checkAll();
        chk("start", {31'd0, start}, {31'd0, mStart});
        chk("done", {31'd0, done}, {31'd0, mDone});
        chk("busy", {31'd0, busy}, {31'd0, mBusy});
        chk("stall", {31'd0, stall}, {31'd0, (!flush && isReq(aluop) && (mBusy || modelNew()))});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, mErr});
        chk("op_a", op_a, mOpA);
        chk("op_b", op_b, mOpB);
        chk("op_sel", {28'd0, op_sel}, {28'd0, mOpSel});
    endtask

    task automatic modelEdge();
        bit r, n;
        r = isReq(aluop);
        n = modelNew();
        mStart = 0;
        mDone  = 0;
        if (flush) begin
            mBusy = 0; mHistValid = 0; mElapsed = 0;
        end else if (!mBusy) begin
            if (n) begin
                mOpA = a; mOpB = b; mOpSel = aluop;
                mHistA = a; mHistB = b; mHistOp = aluop; mHistValid = 1;
                mBusy = 1; mElapsed = 1; mStart = 1;
            end
        end else if (unit_done) begin
            mBusy = 0; mDone = 1;
        end else if (mElapsed == TO) begin
            mBusy = 0; mErr = 1; mHistValid = 0;
        end else begin
            mElapsed++;
        end
        if (!flush && !r) mHistValid = 0;
    endtask

    task automatic step();
        @(negedge clk);
        checkAll();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic drv(logic [3:0] op, logic [31:0] av, logic [31:0] bv, logic fl, logic ud);
        aluop = op; a = av; b = bv; flush = fl; unit_done = ud;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(4'h0, 0, 0, 0, 0);
        modelReset();
        #12;
        chk("rst_start", {31'd0, start}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, timeout_err}, 0);
        chk("rst_opa", op_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Multiply 7*6: start one cycle later, stall until done, no re-issue.
        drv(4'h2, 7, 6, 0, 0);
        step();
        chk("mul_start", {31'd0, start}, 1);
        chk("mul_opa", op_a, 7);
        chk("mul_opb", op_b, 6);
        chk("mul_opsel", {28'd0, op_sel}, 2);
        chk("mul_stall", {31'd0, stall}, 1);
        step(); step(); step();
        chk("mul_busy", {31'd0, busy}, 1);
        unit_done = 1; step(); unit_done = 0;
        chk("mul_done", {31'd0, done}, 1);
        chk("mul_stall_rel", {31'd0, stall}, 0);
        step();
        chk("mul_no_reissue", {31'd0, start}, 0);
        step();

        // Divide, intervening add, identical divide re-issues.
        drv(4'h3, 100, 5, 0, 0);
        step(); step(); step();
        unit_done = 1; step(); unit_done = 0;
        aluop = 4'h0; step();
        aluop = 4'h3; step();
        chk("div_reissue", {31'd0, start}, 1);
        step(); unit_done = 1; step(); unit_done = 0;
        aluop = 4'h0; step();

        // Flush on the third busy cycle together with unit_done.
        drv(4'h2, 21, 2, 0, 0);
        step(); step(); step();
        flush = 1; unit_done = 1; step(); flush = 0; unit_done = 0;
        chk("flush_busy", {31'd0, busy}, 0);
        chk("flush_done", {31'd0, done}, 0);
        step();
        chk("flush_reissue", {31'd0, start}, 1);
        unit_done = 1; step(); unit_done = 0;
        aluop = 4'h0; step();

        // unit_done on the exact timeout cycle wins.
        drv(4'h2, 11, 12, 0, 0);
        step();
        for (int i = 0; i < TO - 1; i++) step();
        unit_done = 1; step(); unit_done = 0;
        chk("edge_done", {31'd0, done}, 1);
        chk("edge_err", {31'd0, timeout_err}, 0);
        aluop = 4'h0; step();

        // Real timeout: no done, sticky error.
        drv(4'h2, 9, 9, 0, 0);
        step();
        for (int i = 0; i < TO; i++) step();
        aluop = 4'h0;
        chk("to_busy", {31'd0, busy}, 0);
        chk("to_err", {31'd0, timeout_err}, 1);
        step(); step();
        chk("to_err_sticky", {31'd0, timeout_err}, 1);

        // Plain add with changing operands and a stray unit_done.
        for (int i = 0; i < 10; i++) begin
            drv(4'h1, $urandom, $urandom, 0, (i == 4));
            step();
            chk("add_start", {31'd0, start}, 0);
            chk("add_stall", {31'd0, stall}, 0);
            chk("add_done", {31'd0, done}, 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 4))
                    0: aluop = 4'h0;
                    1: aluop = 4'h2;
                    2: aluop = 4'h3;
                    3: aluop = 4'h1;
                    default: aluop = 4'($urandom);
                endcase
                a = $urandom_range(0, 3);
                b = $urandom_range(0, 3);
            end
            flush     = ($urandom_range(0, 19) == 0);
            unit_done = mBusy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            step();
        end

        // Asynchronous reset in the middle of an operation.
        drv(4'h2, 55, 66, 0, 0);
        step(); step();
        chk("ar_busy_before", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 0);
        chk("ar_err", {31'd0, timeout_err}, 0);
        chk("ar_opa", op_a, 0);
        modelReset();
        aluop = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_start_ctrl.md
Name: mc_start_ctrl

Overview:
- Issue controller for the multi-cycle ALU functions (multiply, divide) sitting between the execute stage and the iterative mul/div unit.
- Detects a new multi-cycle request from the aluop and operands, latches the operands, and pulses start for one cycle.
- Stalls the pipeline until the unit reports done, then suppresses re-issue of the same request.
- Generalises the earlier fixed 32-bit start detector: parametrised width and opcodes, busy tracking, flush, timeout, and re-issue of identical ops after an intervening instruction.

Parameters:
- WIDTH, 32, operand width
- OPW, 4, aluop width
- OP_MUL, 4'h2, aluop code for multiply
- OP_DIV, 4'h3, aluop code for divide
- TIMEOUT, 64, max BUSY cycles before abort; must be ≥ 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a  in  WIDTH  operand A from execute stage
- b  in  WIDTH  operand B from execute stage
- aluop  in  OPW  ALU operation code
- flush  in  1  pipeline flush; aborts any operation in flight
- unit_done  in  1  one-cycle completion pulse from the mul/div unit
- start  out  1  one-cycle start pulse to the mul/div unit (registered)
- op_a  out  WIDTH  latched operand A to the unit
- op_b  out  WIDTH  latched operand B to the unit
- op_sel  out  OPW  latched aluop to the unit
- busy  out  1  high while the unit is executing (state BUSY)
- stall  out  1  combinational hold request to the pipeline
- done  out  1  registered one-cycle pulse, unit result valid for the pipeline
- timeout_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n. While rst_n is low, all registers are 0:
  - outputs: start, busy, done, timeout_err, op_a, op_b, op_sel
  - internal: hist_valid, hist_a, hist_b, hist_op, cnt, state=IDLE
- Combinational terms:
  - req = (aluop==OP_MUL) | (aluop==OP_DIV)
  - match = hist_valid & (a==hist_a) & (b==hist_b) & (aluop==hist_op)
  - new_req = req & ~match
- History:
  - Any cycle with req=0 and no flush clears hist_valid, so an identical op after a different instruction re-issues.
  - flush clears hist_valid.
- States: IDLE, BUSY.
- IDLE with new_req & ~flush:
  - next edge: op_a<=a, op_b<=b, op_sel<=aluop, hist<=inputs, hist_valid<=1, start<=1, cnt<=0, state<=BUSY.
  - start is visible exactly 1 cycle after the request cycle and is high for exactly 1 cycle.
- BUSY:
  - start<=0, cnt increments each cycle.
  - unit_done & ~flush: state<=IDLE, done<=1 for 1 cycle. hist stays valid, so the held request no longer matches as new.
  - flush (any state, priority over everything): state<=IDLE, start<=0, done<=0, hist_valid<=0, cnt<=0. unit_done in the same cycle is ignored.
  - cnt==TIMEOUT-1 without unit_done: state<=IDLE, timeout_err<=1, hist_valid<=0, no done pulse.
  - unit_done on the same cycle as timeout: done wins, no error.
- Stray inputs: unit_done while IDLE is ignored. Input changes during BUSY are ignored; the pipeline holds them via stall.
- stall = ~flush & req & (busy | new_req).
  - Asserted in the request cycle itself, so the pipeline freezes before start.
  - Deasserts combinationally in the cycle after unit_done, when state is IDLE and match=1.
- Latency: request cycle N → start at N+1 → done at M+1, where unit_done occurs at M.
- Non-multi-cycle aluop never raises start or stall.
- cnt width: $clog2(TIMEOUT+1).
- Reset mid-BUSY returns to IDLE immediately and asynchronously. The unit must be reset by the same rst_n.

Decomposition:
- Shared alu package: OPW, OP_MUL, OP_DIV codes, and the state enum {IDLE, BUSY}.
- Optional sub-module mc_req_tracker: history registers plus match/new_req logic. The remainder (FSM, counter, output latches) stays in mc_start_ctrl.

Test Plan:
- Reset then aluop=2, a=7, b=6 held:
  - start=1 exactly one cycle later; op_a=7, op_b=6, op_sel=2.
  - busy=1 and stall=1 until unit_done.
  - done=1 the cycle after unit_done; stall=0 that cycle; no second start.
- aluop=3, a=100, b=5, done, then aluop=0 for 1 cycle, then aluop=3, a=100, b=5 again → second start pulse issued.
- aluop=2 issued, flush high at cycle 3 of BUSY together with unit_done:
  - state IDLE, done=0, hist_valid=0.
  - the same inputs held afterwards re-issue start.
- TIMEOUT=8, aluop=2 issued, unit_done never asserted → after 8 BUSY cycles busy=0, timeout_err=1 and sticky, done never pulses.
- unit_done on the exact timeout cycle → done=1, timeout_err=0.
- aluop=1 (add) with changing a, b over 10 cycles → start, stall, busy remain 0. unit_done pulsed while IDLE → no done.
